// File: rtl/pll_lock_seq_if.sv
// Signal bundle between the PLL lock sequencer and the PLL wrapper / system side.
// master drives lock and soft-reset requests; slave is the sequencer itself.
interface pll_lock_seq_if;
    logic       pll_locked;
    logic       soft_rst_req;
    logic       pll_reset;
    logic       sys_rst_n;
    logic       ready;
    logic       fail;
    logic [7:0] retry_cnt;
    logic [7:0] lost_lock_cnt;

    modport master (
        output pll_locked,
        output soft_rst_req,
        input  pll_reset,
        input  sys_rst_n,
        input  ready,
        input  fail,
        input  retry_cnt,
        input  lost_lock_cnt
    );

    modport slave (
        input  pll_locked,
        input  soft_rst_req,
        output pll_reset,
        output sys_rst_n,
        output ready,
        output fail,
        output retry_cnt,
        output lost_lock_cnt
    );
endinterface

// File: rtl/pll_lock_seq.sv
// PLL reset/lock sequencer: holds the PLL in reset, waits for stable lock, releases
// the system reset, retries on timeout. Lock-loss counter enabled by PLL_LOCK_LOSS_CNT_EN.
//
// state        | meaning
// -------------+---------------------------------------------------------------
// RESET_HOLD   | pll_reset asserted for RST_HOLD_CYC edges
// WAIT_LOCK    | PLL released, waiting for synchronized lock or timeout
// STABLE       | lock seen, must stay high LOCK_STABLE_CYC edges before release
// RUN          | system reset released, ready=1; lock loss re-sequences
// FAIL         | retries exhausted; PLL held in reset until soft/hard reset
module pll_lock_seq #(
    parameter int RST_HOLD_CYC     = 16,
    parameter int LOCK_STABLE_CYC  = 64,
    parameter int LOCK_TIMEOUT_CYC = 65536,
    parameter int MAX_RETRY        = 3
) (
    input  logic           refclk,
    input  logic           reset_n,
    pll_lock_seq_if.slave  bus
);

    localparam int MAX_AB  = (RST_HOLD_CYC > LOCK_STABLE_CYC) ? RST_HOLD_CYC : LOCK_STABLE_CYC;
    localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYC) ? MAX_AB : LOCK_TIMEOUT_CYC;
    localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CW-1:0] HOLD_LAST    = CW'(RST_HOLD_CYC - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYC - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [7:0]    RETRY_LIMIT  = 8'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_RESET_HOLD = 3'd0,
        S_WAIT_LOCK  = 3'd1,
        S_STABLE     = 3'd2,
        S_RUN        = 3'd3,
        S_FAIL       = 3'd4
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          sync_1;
    logic          lock_s;
    logic          pll_reset_q;
    logic          sys_rst_n_q;
    logic          ready_q;
    logic          fail_q;
    logic [7:0]    retry_q;

    // pll_locked comes from the PLL's own clock tree; two flops before use
    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            sync_1 <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            sync_1 <= bus.pll_locked;
            lock_s <= sync_1;
        end
    end

    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_RESET_HOLD;
            cnt         <= '0;
            pll_reset_q <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
            retry_q     <= 8'd0;
        end else if (bus.soft_rst_req) begin
            state       <= S_RESET_HOLD;
            cnt         <= '0;
            pll_reset_q <= 1'b1;
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            fail_q      <= 1'b0;
            retry_q     <= 8'd0;
        end else begin
            case (state)
                S_RESET_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        state       <= S_WAIT_LOCK;
                        cnt         <= '0;
                        pll_reset_q <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        state <= S_STABLE;
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        cnt         <= '0;
                        pll_reset_q <= 1'b1;
                        if (retry_q < RETRY_LIMIT) begin
                            state   <= S_RESET_HOLD;
                            retry_q <= retry_q + 8'd1;
                        end else begin
                            state  <= S_FAIL;
                            fail_q <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_STABLE: begin
                    if (!lock_s) begin
                        state <= S_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STABLE_LAST) begin
                        state       <= S_RUN;
                        cnt         <= '0;
                        sys_rst_n_q <= 1'b1;
                        ready_q     <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_RUN: begin
                    if (!lock_s) begin
                        state       <= S_RESET_HOLD;
                        cnt         <= '0;
                        pll_reset_q <= 1'b1;
                        sys_rst_n_q <= 1'b0;
                        ready_q     <= 1'b0;
                        retry_q     <= 8'd0;
                    end
                end
                S_FAIL: begin
                    pll_reset_q <= 1'b1;
                    sys_rst_n_q <= 1'b0;
                    ready_q     <= 1'b0;
                    fail_q      <= 1'b1;
                end
                default: begin
                    state       <= S_RESET_HOLD;
                    cnt         <= '0;
                    pll_reset_q <= 1'b1;
                    sys_rst_n_q <= 1'b0;
                    ready_q     <= 1'b0;
                    fail_q      <= 1'b0;
                    retry_q     <= 8'd0;
                end
            endcase
        end
    end

    assign bus.pll_reset = pll_reset_q;
    assign bus.sys_rst_n = sys_rst_n_q;
    assign bus.ready     = ready_q;
    assign bus.fail      = fail_q;
    assign bus.retry_cnt = retry_q;

`ifdef PLL_LOCK_LOSS_CNT_EN
    logic [7:0] lost_q;
    logic       lost_evt;

    // a soft request in the same cycle still counts the loss
    assign lost_evt = (state == S_RUN) && !lock_s;

    always_ff @(posedge refclk or negedge reset_n) begin
        if (!reset_n) begin
            lost_q <= 8'd0;
        end else if (lost_evt && (lost_q != 8'hFF)) begin
            lost_q <= lost_q + 8'd1;
        end
    end

    assign bus.lost_lock_cnt = lost_q;
`else
    assign bus.lost_lock_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_seq.sv
// Directed bench for pll_lock_seq with short timeout (1024) and MAX_RETRY=2.
module tb_pll_lock_seq;

`ifdef PLL_LOCK_LOSS_CNT_EN
    localparam bit LOSS_EN = 1'b1;
`else
    localparam bit LOSS_EN = 1'b0;
`endif

    logic refclk  = 1'b0;
    logic reset_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    pll_lock_seq_if bus();

    pll_lock_seq #(
        .RST_HOLD_CYC     (16),
        .LOCK_STABLE_CYC  (64),
        .LOCK_TIMEOUT_CYC (1024),
        .MAX_RETRY        (2)
    ) dut (
        .refclk  (refclk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #4 refclk = ~refclk;

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic do_reset(input logic lock);
        reset_n          = 1'b0;
        bus.soft_rst_req = 1'b0;
        bus.pll_locked   = lock;
        repeat (3) tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        bus.pll_locked   = 1'b1;
        bus.soft_rst_req = 1'b0;
        reset_n          = 1'b0;
        repeat (2) tick();
        n_tests++; if (bus.pll_reset !== 1'b1) begin n_fail++; $display("FAIL reset pll_reset got %b want 1", bus.pll_reset); end
        n_tests++; if (bus.sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL reset sys_rst_n got %b want 0", bus.sys_rst_n); end
        n_tests++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL reset ready got %b want 0", bus.ready); end
        n_tests++; if (bus.fail !== 1'b0) begin n_fail++; $display("FAIL reset fail got %b want 0", bus.fail); end
        n_tests++; if (bus.retry_cnt !== 8'd0) begin n_fail++; $display("FAIL reset retry_cnt got %0d want 0", bus.retry_cnt); end
        n_tests++; if (bus.lost_lock_cnt !== 8'd0) begin n_fail++; $display("FAIL reset lost_lock_cnt got %0d want 0", bus.lost_lock_cnt); end
    endtask

    // lock held high: pll_reset falls at edge 16, release at edge 81
    task automatic test_nominal();
        logic exp_pr, exp_run;
        do_reset(1'b1);
        for (int e = 1; e <= 100; e++) begin
            tick();
            exp_pr  = (e < 16);
            exp_run = (e >= 81);
            n_tests++; if (bus.pll_reset !== exp_pr) begin n_fail++; $display("FAIL nominal pll_reset edge %0d got %b want %b", e, bus.pll_reset, exp_pr); end
            n_tests++; if (bus.sys_rst_n !== exp_run) begin n_fail++; $display("FAIL nominal sys_rst_n edge %0d got %b want %b", e, bus.sys_rst_n, exp_run); end
            n_tests++; if (bus.ready !== exp_run) begin n_fail++; $display("FAIL nominal ready edge %0d got %b want %b", e, bus.ready, exp_run); end
        end
        n_tests++; if (bus.retry_cnt !== 8'd0) begin n_fail++; $display("FAIL nominal retry_cnt got %0d want 0", bus.retry_cnt); end
        n_tests++; if (bus.fail !== 1'b0) begin n_fail++; $display("FAIL nominal fail got %b want 0", bus.fail); end
    endtask

    // soft request from RUN with lock steady: restarts, no lock loss counted
    task automatic test_soft_req_run();
        logic exp_pr, exp_run;
        bus.soft_rst_req = 1'b1;
        tick();
        bus.soft_rst_req = 1'b0;
        n_tests++; if (bus.pll_reset !== 1'b1) begin n_fail++; $display("FAIL soft_run pll_reset got %b want 1", bus.pll_reset); end
        n_tests++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL soft_run ready got %b want 0", bus.ready); end
        n_tests++; if (bus.sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL soft_run sys_rst_n got %b want 0", bus.sys_rst_n); end
        n_tests++; if (bus.lost_lock_cnt !== 8'd0) begin n_fail++; $display("FAIL soft_run lost_lock_cnt got %0d want 0", bus.lost_lock_cnt); end
        for (int e = 1; e <= 81; e++) begin
            tick();
            exp_pr  = (e < 16);
            exp_run = (e >= 81);
            n_tests++; if (bus.pll_reset !== exp_pr) begin n_fail++; $display("FAIL soft_run pll_reset edge %0d got %b want %b", e, bus.pll_reset, exp_pr); end
            n_tests++; if (bus.ready !== exp_run) begin n_fail++; $display("FAIL soft_run ready edge %0d got %b want %b", e, bus.ready, exp_run); end
        end
    endtask

    // no lock: three 16-cycle pll_reset pulses 1040 edges apart, then FAIL at 3120
    task automatic test_timeout_fail();
        logic       exp_pr, exp_fail;
        logic [7:0] exp_retry;
        do_reset(1'b0);
        for (int e = 1; e <= 3130; e++) begin
            tick();
            if (e >= 3120) begin
                exp_pr = 1'b1; exp_fail = 1'b1; exp_retry = 8'd2;
            end else begin
                exp_pr = ((e % 1040) < 16); exp_fail = 1'b0; exp_retry = 8'(e / 1040);
            end
            n_tests++; if (bus.pll_reset !== exp_pr) begin n_fail++; $display("FAIL timeout pll_reset edge %0d got %b want %b", e, bus.pll_reset, exp_pr); end
            n_tests++; if (bus.fail !== exp_fail) begin n_fail++; $display("FAIL timeout fail edge %0d got %b want %b", e, bus.fail, exp_fail); end
            n_tests++; if (bus.retry_cnt !== exp_retry) begin n_fail++; $display("FAIL timeout retry_cnt edge %0d got %0d want %0d", e, bus.retry_cnt, exp_retry); end
            n_tests++; if (bus.sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL timeout sys_rst_n edge %0d got %b want 0", e, bus.sys_rst_n); end
        end
        bus.soft_rst_req = 1'b1;
        tick();
        bus.soft_rst_req = 1'b0;
        n_tests++; if (bus.fail !== 1'b0) begin n_fail++; $display("FAIL soft_fail fail got %b want 0", bus.fail); end
        n_tests++; if (bus.retry_cnt !== 8'd0) begin n_fail++; $display("FAIL soft_fail retry_cnt got %0d want 0", bus.retry_cnt); end
        for (int e = 1; e <= 16; e++) begin
            tick();
            exp_pr = (e < 16);
            n_tests++; if (bus.pll_reset !== exp_pr) begin n_fail++; $display("FAIL soft_fail pll_reset edge %0d got %b want %b", e, bus.pll_reset, exp_pr); end
        end
    endtask

    // lock high after edge 20, low for edges 61..63, high again: release at edge 130
    task automatic test_glitch();
        logic exp_run;
        do_reset(1'b0);
        for (int e = 1; e <= 135; e++) begin
            tick();
            exp_run = (e >= 130);
            n_tests++; if (bus.sys_rst_n !== exp_run) begin n_fail++; $display("FAIL glitch sys_rst_n edge %0d got %b want %b", e, bus.sys_rst_n, exp_run); end
            n_tests++; if (bus.ready !== exp_run) begin n_fail++; $display("FAIL glitch ready edge %0d got %b want %b", e, bus.ready, exp_run); end
            n_tests++; if (bus.retry_cnt !== 8'd0) begin n_fail++; $display("FAIL glitch retry_cnt edge %0d got %0d want 0", e, bus.retry_cnt); end
            if (e == 20) bus.pll_locked = 1'b1;
            if (e == 60) bus.pll_locked = 1'b0;
            if (e == 63) bus.pll_locked = 1'b1;
        end
    endtask

    // from RUN: lock low for 5 edges; drop seen at edge 3, RUN again at edge 84
    task automatic test_lock_loss();
        logic       exp_run, exp_pr;
        logic [7:0] exp_lost;
        bus.pll_locked = 1'b0;
        for (int j = 1; j <= 90; j++) begin
            tick();
            exp_run  = (j <= 2) || (j >= 84);
            exp_pr   = (j >= 3) && (j <= 18);
            exp_lost = (j >= 3) ? 8'(LOSS_EN) : 8'd0;
            n_tests++; if (bus.sys_rst_n !== exp_run) begin n_fail++; $display("FAIL lockloss sys_rst_n edge %0d got %b want %b", j, bus.sys_rst_n, exp_run); end
            n_tests++; if (bus.pll_reset !== exp_pr) begin n_fail++; $display("FAIL lockloss pll_reset edge %0d got %b want %b", j, bus.pll_reset, exp_pr); end
            n_tests++; if (bus.lost_lock_cnt !== exp_lost) begin n_fail++; $display("FAIL lockloss lost_lock_cnt edge %0d got %0d want %0d", j, bus.lost_lock_cnt, exp_lost); end
            n_tests++; if (bus.retry_cnt !== 8'd0) begin n_fail++; $display("FAIL lockloss retry_cnt edge %0d got %0d want 0", j, bus.retry_cnt); end
            if (j == 5) bus.pll_locked = 1'b1;
        end
    endtask

    // 257 single-cycle lock drops from RUN; count saturates at 255 (0 when disabled)
    task automatic test_saturation();
        logic [7:0] exp_lost;
        do_reset(1'b1);
        for (int k = 0; k < 200 && !bus.ready; k++) tick();
        n_tests++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL sat initial ready got %b want 1", bus.ready); end
        for (int i = 1; i <= 257; i++) begin
            bus.pll_locked = 1'b0;
            tick();
            bus.pll_locked = 1'b1;
            tick();
            tick();
            exp_lost = LOSS_EN ? ((i > 255) ? 8'd255 : 8'(i)) : 8'd0;
            n_tests++; if (bus.lost_lock_cnt !== exp_lost) begin n_fail++; $display("FAIL sat lost_lock_cnt loss %0d got %0d want %0d", i, bus.lost_lock_cnt, exp_lost); end
            n_tests++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL sat ready after loss %0d got %b want 0", i, bus.ready); end
            for (int k = 0; k < 200 && !bus.ready; k++) tick();
            n_tests++; if (bus.ready !== 1'b1) begin n_fail++; $display("FAIL sat ready timeout loss %0d got %b want 1", i, bus.ready); end
        end
    endtask

    // reach STABLE after a lock drop, then assert reset_n between edges
    task automatic test_async_reset();
        logic exp_pr, exp_run;
        bus.pll_locked = 1'b0;
        tick();
        bus.pll_locked = 1'b1;
        repeat (44) tick();
        n_tests++; if (bus.pll_reset !== 1'b0) begin n_fail++; $display("FAIL async pre pll_reset got %b want 0", bus.pll_reset); end
        #2;
        reset_n = 1'b0;
        #1;
        n_tests++; if (bus.pll_reset !== 1'b1) begin n_fail++; $display("FAIL async pll_reset got %b want 1", bus.pll_reset); end
        n_tests++; if (bus.sys_rst_n !== 1'b0) begin n_fail++; $display("FAIL async sys_rst_n got %b want 0", bus.sys_rst_n); end
        n_tests++; if (bus.ready !== 1'b0) begin n_fail++; $display("FAIL async ready got %b want 0", bus.ready); end
        n_tests++; if (bus.fail !== 1'b0) begin n_fail++; $display("FAIL async fail got %b want 0", bus.fail); end
        n_tests++; if (bus.retry_cnt !== 8'd0) begin n_fail++; $display("FAIL async retry_cnt got %0d want 0", bus.retry_cnt); end
        n_tests++; if (bus.lost_lock_cnt !== 8'd0) begin n_fail++; $display("FAIL async lost_lock_cnt got %0d want 0", bus.lost_lock_cnt); end
        reset_n = 1'b1;
        for (int e = 1; e <= 81; e++) begin
            tick();
            exp_pr  = (e < 16);
            exp_run = (e >= 81);
            n_tests++; if (bus.pll_reset !== exp_pr) begin n_fail++; $display("FAIL async_rel pll_reset edge %0d got %b want %b", e, bus.pll_reset, exp_pr); end
            n_tests++; if (bus.ready !== exp_run) begin n_fail++; $display("FAIL async_rel ready edge %0d got %b want %b", e, bus.ready, exp_run); end
        end
    endtask

    initial begin
        bus.pll_locked   = 1'b1;
        bus.soft_rst_req = 1'b0;
        test_reset();
        test_nominal();
        test_soft_req_run();
        test_timeout_fail();
        test_glitch();
        test_lock_loss();
        test_saturation();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
